uart_tx_arbiter: RTL

- Shares the single UART transmitter (txStart/txData/txBusy handshake) between NREQ byte-stream requesters, e.g. the serial command processor's reply path and autonomous histogram/trigger streamers.
- Requesters present packets one byte at a time with a last flag.
- The arbiter grants round-robin at packet boundaries and keeps the grant locked until the packet's last byte has left the transmitter.
- A mid-packet stall watchdog releases a hung requester so the link cannot deadlock.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream
// requesters; grants are locked per packet and released by a stall watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NREQ          = 2,
    parameter int unsigned BUSY_RISE_MAX = 4,
    parameter int unsigned STALL_MAX     = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              txBusy,
    output logic              txStart,
    output logic [7:0]        txData,
    output logic [NREQ-1:0]   grant,
    output logic              active,
    output logic [7:0]        stall_count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam int unsigned BW = (BUSY_RISE_MAX > 1) ? $clog2(BUSY_RISE_MAX) : 1;

    localparam logic [IW-1:0] RR_INIT    = IW'(NREQ - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [BW-1:0] RISE_LAST  = BW'(BUSY_RISE_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            last_q;
    logic            xfer;
    logic [SW-1:0]   stall_cnt;
    logic [BW-1:0]   rise_cnt;

    // Round-robin search: indices above rr first, then wrap to 0..rr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i] && (i > 32'(rr))) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i] && (i <= 32'(rr))) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == ARM && !txBusy) begin
            req_ready = grant & req_valid;
        end
    end

    assign xfer    = |req_ready;
    assign txStart = (state == START);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_found) state_nx = ARM;
            ARM: begin
                if (xfer) begin
                    state_nx = START;
                end else if (stall_cnt == STALL_LAST) begin
                    state_nx = IDLE;
                end
            end
            START:   state_nx = WAIT_HI;
            // A busy-rise timeout passes through WAIT_LO so both paths share
            // the same release/re-arm decision one cycle later.
            WAIT_HI: if (txBusy || rise_cnt == RISE_LAST) state_nx = WAIT_LO;
            WAIT_LO: if (!txBusy) state_nx = last_q ? IDLE : ARM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr          <= RR_INIT;
            txData      <= '0;
            grant       <= '0;
            active      <= 1'b0;
            stall_count <= '0;
            last_q      <= 1'b0;
            stall_cnt   <= '0;
            rise_cnt    <= '0;
        end else begin
            state <= state_nx;
            // Watchdog measures time since the last accepted byte (or grant),
            // so it keeps counting while that byte is on the wire.
            if (active && stall_cnt != STALL_LAST) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant     <= NREQ'(1) << pick_idx;
                        active    <= 1'b1;
                        rr        <= pick_idx;
                        stall_cnt <= '0;
                    end
                end
                ARM: begin
                    if (xfer) begin
                        txData    <= sel_data;
                        last_q    <= sel_last;
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_LAST) begin
                        grant  <= '0;
                        active <= 1'b0;
                        if (stall_count != 8'hFF) begin
                            stall_count <= stall_count + 8'd1;
                        end
                    end
                end
                START: rise_cnt <= '0;
                WAIT_HI: begin
                    if (!txBusy && rise_cnt != RISE_LAST) begin
                        rise_cnt <= rise_cnt + BW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!txBusy && last_q) begin
                        grant  <= '0;
                        active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
